// File: rtl/vending_fsm_param_if.sv
// Vending controller bus: groups the front-end strobes (coin acceptor, keypad,
// cancel button) and the controller's responses (credit, affordability,
// dispense/change pulses, debug state).
//   master : front end / bench, drives coin, coin_valid, drink_choose,
//            choose_valid and cancel; observes everything else.
//   slave  : the controller, the mirror image.
interface vending_fsm_param_if #(
  parameter int COIN_W   = 32,
  parameter int N_DRINKS = 4,
  parameter int SEL_W    = 2
);
  logic [COIN_W-1:0]   coin;
  logic                coin_valid;
  logic [SEL_W-1:0]    drink_choose;
  logic                choose_valid;
  logic                cancel;
  logic [COIN_W-1:0]   total_coin;
  logic [N_DRINKS-1:0] affordable;
  logic                coin_reject;
  logic                choose_reject;
  logic [SEL_W-1:0]    drink_out;
  logic                drink_valid;
  logic [COIN_W-1:0]   change;
  logic                change_valid;
  logic [1:0]          state;

  modport master (
    output coin, coin_valid, drink_choose, choose_valid, cancel,
    input  total_coin, affordable, coin_reject, choose_reject,
           drink_out, drink_valid, change, change_valid, state
  );

  modport slave (
    input  coin, coin_valid, drink_choose, choose_valid, cancel,
    output total_coin, affordable, coin_reject, choose_reject,
           drink_out, drink_valid, change, change_valid, state
  );
endinterface

// File: rtl/vending_fsm_param.sv
// Parametrised vending-machine controller.
// Accumulates coins (rejecting any that would exceed MAX_CREDIT), reports which
// drinks the current credit covers, dispenses an affordable selection and then
// returns the remaining credit as change. Cancel and an inactivity timeout both
// refund the full credit.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-low (0 = reset)
//   bus   : vending_fsm_param_if slave modport (strobes in, credit/pulses out)
module vending_fsm_param #(
  parameter int                           COIN_W     = 32,
  parameter int                           N_DRINKS   = 4,
  parameter int                           SEL_W      = 2,
  parameter logic [N_DRINKS*COIN_W-1:0]   PRICES     = {32'd25, 32'd20, 32'd15, 32'd10},
  parameter int                           MAX_CREDIT = 100,
  parameter int                           TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  vending_fsm_param_if.slave    bus
);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  function automatic logic [COIN_W-1:0] min_price_f();
    logic [COIN_W-1:0] m;
    m = PRICES[COIN_W-1:0];
    for (int i = 1; i < N_DRINKS; i++) begin
      if (PRICES[i*COIN_W +: COIN_W] < m) m = PRICES[i*COIN_W +: COIN_W];
    end
    return m;
  endfunction

  localparam logic [COIN_W-1:0] MIN_PRICE = min_price_f();
  localparam logic [COIN_W:0]   MAX_CR    = (COIN_W+1)'(MAX_CREDIT);
  localparam logic [31:0]       TO_LAST   = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t              state_q;
  logic [COIN_W-1:0]   total_q;
  logic [COIN_W-1:0]   change_q;
  logic [SEL_W-1:0]    drink_out_q;
  logic [SEL_W-1:0]    sel_q;
  logic [COIN_W-1:0]   price_q;
  logic                coin_reject_q;
  logic                choose_reject_q;
  logic                drink_valid_q;
  logic                change_valid_q;
  logic [31:0]         timer_q;

  logic [N_DRINKS-1:0] afford_w;
  logic [COIN_W:0]     sum_w;
  logic                coin_ok_w;
  logic                coin_bad_w;
  logic                sel_ok_w;
  logic [COIN_W-1:0]   sel_price_w;
  logic                idle_w;
  logic                timeout_w;
  logic [31:0]         timer_d;

  for (genvar gi = 0; gi < N_DRINKS; gi++) begin : g_afford
    assign afford_w[gi] = (total_q >= PRICES[gi*COIN_W +: COIN_W]);
  end

  // One extra bit on the sum so a large coin can never wrap past MAX_CREDIT.
  assign sum_w      = {1'b0, total_q} + {1'b0, bus.coin};
  assign coin_ok_w  = bus.coin_valid && (bus.coin != '0) && (sum_w <= MAX_CR);
  assign coin_bad_w = bus.coin_valid && (bus.coin != '0) && !(sum_w <= MAX_CR);

  // Out-of-range indices match no entry and so are never affordable.
  always_comb begin
    sel_ok_w    = 1'b0;
    sel_price_w = '0;
    for (int i = 0; i < N_DRINKS; i++) begin
      if (bus.drink_choose == SEL_W'(i)) begin
        sel_ok_w    = afford_w[i];
        sel_price_w = PRICES[i*COIN_W +: COIN_W];
      end
    end
  end

  // Any strobe counts as activity; ">=" rather than "==" keeps the refund
  // armed even if a rejected strobe let the timer step past the threshold.
  assign idle_w    = !bus.coin_valid && !bus.choose_valid && !bus.cancel;
  assign timeout_w = (TIMEOUT != 0) && (timer_q >= TO_LAST) && idle_w;
  assign timer_d   = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= COLLECT;
      total_q         <= '0;
      change_q        <= '0;
      drink_out_q     <= '0;
      sel_q           <= '0;
      price_q         <= '0;
      coin_reject_q   <= 1'b0;
      choose_reject_q <= 1'b0;
      drink_valid_q   <= 1'b0;
      change_valid_q  <= 1'b0;
      timer_q         <= '0;
    end else begin
      coin_reject_q   <= 1'b0;
      choose_reject_q <= 1'b0;
      drink_valid_q   <= 1'b0;
      change_valid_q  <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (bus.choose_valid) choose_reject_q <= 1'b1;
          if (bus.cancel && total_q != '0) begin
            // Coin arriving with the refund would be lost; hand it back.
            if (bus.coin_valid) coin_reject_q <= 1'b1;
            state_q <= CHANGE;
            timer_q <= '0;
          end else begin
            if (coin_ok_w) total_q <= sum_w[COIN_W-1:0];
            if (coin_bad_w) coin_reject_q <= 1'b1;
            if (total_q >= MIN_PRICE) begin
              state_q <= SELECT;
              timer_q <= '0;
            end else if (coin_ok_w || bus.choose_valid) begin
              timer_q <= '0;
            end else if (total_q != '0) begin
              if (timeout_w) begin
                state_q <= CHANGE;
                timer_q <= '0;
              end else begin
                timer_q <= timer_d;
              end
            end
          end
        end
        SELECT: begin
          if (bus.cancel) begin
            if (bus.coin_valid)   coin_reject_q   <= 1'b1;
            if (bus.choose_valid) choose_reject_q <= 1'b1;
            state_q <= CHANGE;
            timer_q <= '0;
          end else if (bus.choose_valid && sel_ok_w) begin
            if (bus.coin_valid) coin_reject_q <= 1'b1;
            sel_q   <= bus.drink_choose;
            price_q <= sel_price_w;
            state_q <= DISPENSE;
            timer_q <= '0;
          end else begin
            if (bus.choose_valid) choose_reject_q <= 1'b1;
            if (coin_ok_w) total_q <= sum_w[COIN_W-1:0];
            if (coin_bad_w) coin_reject_q <= 1'b1;
            if (coin_ok_w || bus.choose_valid) begin
              timer_q <= '0;
            end else if (timeout_w) begin
              state_q <= CHANGE;
              timer_q <= '0;
            end else begin
              timer_q <= timer_d;
            end
          end
        end
        DISPENSE: begin
          if (bus.coin_valid)   coin_reject_q   <= 1'b1;
          if (bus.choose_valid) choose_reject_q <= 1'b1;
          drink_valid_q <= 1'b1;
          drink_out_q   <= sel_q;
          total_q       <= total_q - price_q;
          state_q       <= CHANGE;
          timer_q       <= '0;
        end
        default: begin // CHANGE
          if (bus.coin_valid)   coin_reject_q   <= 1'b1;
          if (bus.choose_valid) choose_reject_q <= 1'b1;
          change_q       <= total_q;
          change_valid_q <= 1'b1;
          total_q        <= '0;
          state_q        <= COLLECT;
          timer_q        <= '0;
        end
      endcase
    end
  end

  assign bus.total_coin    = total_q;
  assign bus.affordable    = afford_w;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.choose_reject = choose_reject_q;
  assign bus.drink_out     = drink_out_q;
  assign bus.drink_valid   = drink_valid_q;
  assign bus.change        = change_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
module tb_vending_fsm_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  vending_fsm_param_if #(.COIN_W(32), .N_DRINKS(4), .SEL_W(2)) bus ();

  vending_fsm_param #(
    .COIN_W(32), .N_DRINKS(4), .SEL_W(2),
    .PRICES({32'd25, 32'd20, 32'd15, 32'd10}),
    .MAX_CREDIT(100), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.coin = '0; bus.coin_valid = 1'b0; bus.drink_choose = '0;
    bus.choose_valid = 1'b0; bus.cancel = 1'b0;
  endtask

  // One rising edge; outputs are sampled 1 time unit later, then inputs go idle.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic coin_step(input int v);
    bus.coin = 32'(v); bus.coin_valid = 1'b1;
    step();
    $display("coin %0d -> total=%0d reject=%0b state=%0d", v, bus.total_coin, bus.coin_reject, bus.state);
    idle_in();
  endtask

  task automatic choose_step(input int d);
    bus.drink_choose = 2'(d); bus.choose_valid = 1'b1;
    step();
    $display("choose %0d -> state=%0d choose_reject=%0b", d, bus.state, bus.choose_reject);
    idle_in();
  endtask

  initial begin
    idle_in();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    $display("reset released: state=%0d total=%0d", bus.state, bus.total_coin);
    chk("init_state", bus.state, 0);
    chk("init_total", bus.total_coin, 0);
    chk("init_pulses", {bus.coin_reject, bus.choose_reject, bus.drink_valid, bus.change_valid}, 0);

    // Reset in the middle of SELECT with credit 15
    coin_step(10);
    coin_step(5);
    chk("presel_state", bus.state, 1);
    chk("presel_total", bus.total_coin, 15);
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    $display("mid-select reset: state=%0d total=%0d", bus.state, bus.total_coin);
    chk("rst_state", bus.state, 0);
    chk("rst_total", bus.total_coin, 0);
    chk("rst_pulses", {bus.coin_reject, bus.choose_reject, bus.drink_valid, bus.change_valid}, 0);
    chk("rst_change", bus.change, 0);
    chk("rst_drink_out", bus.drink_out, 0);

    // 10+5+10 = 25, buy milk (25), change 0
    coin_step(10); coin_step(5); coin_step(10);
    chk("c25_total", bus.total_coin, 25);
    chk("c25_afford", bus.affordable, 4'b1111);
    choose_step(3);
    chk("milk_dispense_state", bus.state, 2);
    chk("milk_no_early_drink", bus.drink_valid, 0);
    step();
    $display("dispense: drink_valid=%0b drink_out=%0d total=%0d", bus.drink_valid, bus.drink_out, bus.total_coin);
    chk("milk_drink_valid", bus.drink_valid, 1);
    chk("milk_drink_out", bus.drink_out, 3);
    chk("milk_total_after", bus.total_coin, 0);
    step();
    $display("change: valid=%0b change=%0d state=%0d", bus.change_valid, bus.change, bus.state);
    chk("milk_change_valid", bus.change_valid, 1);
    chk("milk_change", bus.change, 0);
    chk("milk_back_collect", bus.state, 0);
    chk("milk_drink_pulse_end", bus.drink_valid, 0);

    // 20 credit: milk refused, tea bought, change 10
    coin_step(10); coin_step(10);
    chk("c20_afford", bus.affordable, 4'b0111);
    choose_step(3);
    chk("milk20_reject", bus.choose_reject, 1);
    chk("milk20_state", bus.state, 1);
    chk("milk20_total", bus.total_coin, 20);
    choose_step(0);
    chk("tea_state", bus.state, 2);
    step();
    chk("tea_drink_valid", bus.drink_valid, 1);
    chk("tea_drink_out", bus.drink_out, 0);
    step();
    $display("tea change: valid=%0b change=%0d", bus.change_valid, bus.change);
    chk("tea_change_valid", bus.change_valid, 1);
    chk("tea_change", bus.change, 10);

    // Credit ceiling: 50+50 accepted, 10 rejected
    coin_step(50); coin_step(50);
    chk("max_total", bus.total_coin, 100);
    chk("max_no_reject", bus.coin_reject, 0);
    coin_step(10);
    chk("over_reject", bus.coin_reject, 1);
    chk("over_total", bus.total_coin, 100);
    // Coffee chosen with a coin in the same cycle: coin handed back
    bus.coin = 32'd5; bus.coin_valid = 1'b1;
    bus.drink_choose = 2'd2; bus.choose_valid = 1'b1;
    step();
    $display("choose+coin: state=%0d coin_reject=%0b", bus.state, bus.coin_reject);
    idle_in();
    chk("choose_coin_reject", bus.coin_reject, 1);
    chk("choose_coin_state", bus.state, 2);
    step();
    chk("coffee_drink_out", bus.drink_out, 2);
    chk("coffee_total", bus.total_coin, 80);
    step();
    chk("coffee_change", bus.change, 80);
    chk("coffee_change_valid", bus.change_valid, 1);

    // Cancel beats choose in the same cycle
    coin_step(10); coin_step(5);
    bus.cancel = 1'b1; bus.drink_choose = 2'd0; bus.choose_valid = 1'b1;
    step();
    $display("cancel+choose: state=%0d choose_reject=%0b", bus.state, bus.choose_reject);
    idle_in();
    chk("cancel_choose_reject", bus.choose_reject, 1);
    chk("cancel_state", bus.state, 3);
    step();
    chk("cancel_change_valid", bus.change_valid, 1);
    chk("cancel_change", bus.change, 15);
    chk("cancel_total", bus.total_coin, 0);
    // Cancel with no credit does nothing
    bus.cancel = 1'b1;
    step();
    idle_in();
    chk("cancel0_state", bus.state, 0);
    step();
    chk("cancel0_no_change", bus.change_valid, 0);

    // Timeout: credit 20, idle until refund
    coin_step(10); coin_step(10);
    for (int i = 0; i < 7; i++) step();
    chk("to_still_select", bus.state, 1);
    step();
    chk("to_change_state", bus.state, 3);
    step();
    $display("timeout refund: valid=%0b change=%0d state=%0d", bus.change_valid, bus.change, bus.state);
    chk("to_change_valid", bus.change_valid, 1);
    chk("to_change", bus.change, 20);
    chk("to_collect", bus.state, 0);

    // A coin at idle cycle 5 restarts the count
    coin_step(10); coin_step(10);
    for (int i = 0; i < 4; i++) step();
    coin_step(5);
    for (int i = 0; i < 7; i++) step();
    chk("to_restart_select", bus.state, 1);
    chk("to_restart_total", bus.total_coin, 25);
    step();
    chk("to_restart_change_state", bus.state, 3);
    step();
    chk("to_restart_change", bus.change, 25);
    chk("to_restart_valid", bus.change_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vending_fsm_param.md
Name: vending_fsm_param

Overview:
Parametrised vending-machine controller, the successor to the fixed four-drink coin FSM. It accumulates coins under a valid strobe and exposes which drinks are currently affordable. It accepts a drink selection, dispenses, and returns change. Over-credit coins are rejected, and cancel and an inactivity timeout both refund the full credit. It sits between the coin-acceptor/keypad front end and the dispenser/change-hopper drivers.

Parameters:
COIN_W, 32, width of coin, credit and change values
N_DRINKS, 4, number of selectable drinks (>=1)
SEL_W, 2, width of drink index (>= clog2(N_DRINKS), >=1)
PRICES, {32'd25,32'd20,32'd15,32'd10}, packed N_DRINKS*COIN_W price table; drink i at bits [i*COIN_W +: COIN_W]; default tea=10, coke=15, coffee=20, milk=25
MAX_CREDIT, 100, upper limit on total_coin
TIMEOUT, 1000, idle cycles in SELECT (or COLLECT with credit) before auto-refund; 0 disables

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
coin  input  COIN_W  coin value inserted
coin_valid  input  1  coin strobe, one coin per asserted cycle
drink_choose  input  SEL_W  requested drink index
choose_valid  input  1  selection strobe
cancel  input  1  refund request
total_coin  output  COIN_W  current credit (registered)
affordable  output  N_DRINKS  bit i = (total_coin >= PRICE[i]), combinational from registered total_coin
coin_reject  output  1  one-cycle pulse: coin not accepted, returned physically
choose_reject  output  1  one-cycle pulse: selection refused
drink_out  output  SEL_W  index of dispensed drink, held until next dispense
drink_valid  output  1  one-cycle dispense pulse
change  output  COIN_W  refund/change amount, held until next CHANGE
change_valid  output  1  one-cycle change pulse
state  output  2  current state, for debug

Behaviour:
- Reset (reset==0 at clk edge): state=COLLECT; total_coin, change, drink_out, timer=0; all pulses 0. Reset overrides everything, including a mid-dispense.
- States: COLLECT=0, SELECT=1, DISPENSE=2, CHANGE=3. MIN_PRICE = min over PRICES.
- Coin acceptance (COLLECT and SELECT only): a coin with coin_valid=1 and coin!=0 is accepted if total_coin+coin <= MAX_CREDIT (compute in COIN_W+1 bits, so no wrap), and then total_coin += coin next cycle. Otherwise coin_reject=1 next cycle and total_coin is unchanged. A coin with value 0 is ignored with no reject. A coin_valid in DISPENSE or CHANGE gives coin_reject.
- COLLECT: transition to SELECT on the edge where registered total_coin >= MIN_PRICE, so there is 1 cycle of latency after the crediting edge. cancel with total_coin>0 goes to CHANGE; cancel with total_coin==0 is ignored.
- SELECT: accepted coins keep adding credit. Priority in the same cycle is cancel > choose_valid > coin_valid.
  - cancel: go to CHANGE; any same-cycle coin or choose is rejected.
  - choose_valid with drink_choose < N_DRINKS and affordable[drink_choose]: latch the selection and go to DISPENSE. A same-cycle coin is rejected.
  - Otherwise choose_reject pulses and the state stays SELECT.
- DISPENSE (exactly 1 cycle): drink_valid=1 and drink_out=selection on the following edge, total_coin -= PRICE[sel], then go to CHANGE.
- CHANGE (exactly 1 cycle): change<=total_coin, change_valid=1 (pulses even when the value is 0), total_coin<=0, then go to COLLECT.
- Latency from choose to change_valid: choose edge -> DISPENSE -> drink_valid with CHANGE -> change_valid with COLLECT, so drink_valid comes 1 cycle after the choose edge and change_valid 2 cycles after.
- Timer: cleared on any accepted coin, choose or state change; increments in SELECT, and in COLLECT when total_coin>0. When timer==TIMEOUT-1 and there is no activity, go to CHANGE (full refund). The timer saturates and does not wrap.
- Credit never exceeds MAX_CREDIT and never underflows, because only affordable drinks are dispensed.

Test Plan:
- Reset held low 2 cycles mid-SELECT with total_coin=15 -> total_coin=0, state=COLLECT, all pulses 0.
- Coins 10, 5, 10 -> total_coin=25, affordable=4'b1111. Choose 3 (milk) -> drink_valid with drink_out=3, then change_valid with change=0, then state=COLLECT.
- Coins 10, 10, choose 0 (tea) -> drink_out=0, change=10. Choose 3 with credit 20 -> choose_reject, state stays SELECT, credit unchanged.
- MAX_CREDIT=100, coins 50, 50, 10 -> third coin gets coin_reject and total_coin stays 100. A coin on the same cycle as an accepted choose -> coin_reject.
- Credit 15, then cancel and choose_valid in the same cycle -> choose_reject, change_valid with change=15. Cancel with credit 0 in COLLECT -> no change_valid.
- TIMEOUT=8, credit 20, idle 8 cycles -> change_valid with change=20, state=COLLECT. A coin at idle cycle 5 restarts the count.
